tff_array: RTL and testbench
============================

Name: tff_array

Overview:
- Parametrised synchronous bank of WIDTH toggle flip-flops. Generalises the level-sensitive single-bit T latch to an edge-triggered, multi-bit register.
- Adds parallel load, and up/down counter modes built from the T-chain.
- Intended as the shared building block for dividers, ripple-free counters and toggle-status registers in the sequential-circuits library.

Parameters:
WIDTH, 4, number of T flip-flops (bits) in the bank; legal range 1..32
RST_VAL, 0, value loaded into Q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
En  input  1  global enable; 0 = hold all state
Mode  input  2  00 toggle, 01 load, 10 count up, 11 count down
T  input  WIDTH  per-bit toggle request (Mode 00 only)
D  input  WIDTH  parallel load data (Mode 01 only)
Q  output  WIDTH  registered state
Qn  output  WIDTH  bitwise complement of Q (combinational from Q)
Tc  output  1  registered terminal-count pulse
Chg  output  1  registered flag: Q changed on the previous edge

Behaviour:
- All state updates on rising clk only. No latch or level-transparent behaviour.
- Priority per edge: rst > En=0 > Mode.
- Reset (rst=1 at edge):
  - Q <= RST_VAL, Tc <= 0, Chg <= 0.
  - En, Mode, T and D are ignored.
  - Reset mid-count abandons the count; the next non-reset edge starts from RST_VAL.
- En=0 (rst=0): Q holds; Tc <= 0; Chg <= 0.
- Mode 00 (toggle): Q <= Q ^ T.
  - Bit i toggles iff T[i]=1; T=0 holds all bits.
  - Tc <= 0.
- Mode 01 (load): Q <= D. Tc <= 0.
- Mode 10 (count up):
  - Bit i toggles iff Q[i-1:0] are all 1; bit 0 always toggles. Equivalent to Q+1 mod 2^WIDTH.
  - Wrap from all-ones to 0 sets Tc <= 1 for exactly the cycle after the wrapping edge; otherwise Tc <= 0.
- Mode 11 (count down):
  - Bit i toggles iff Q[i-1:0] are all 0; bit 0 always toggles. Equivalent to Q-1 mod 2^WIDTH.
  - Wrap from 0 to all-ones sets Tc <= 1 for one cycle; otherwise Tc <= 0.
- Chg:
  - Chg <= 1 iff next Q differs from current Q at that edge.
  - Load of a value equal to Q gives Chg=0. Toggle with T=0 gives Chg=0.
- Tc and Chg are single-cycle pulses. They are never asserted on the edge following reset.
- Mode changes take effect on the same edge they are sampled. No pipeline latency: Q reflects the new value one clock after the inputs are sampled.
- Qn = ~Q at all times, including during and after reset.
- WIDTH=1:
  - Counting up or down toggles Q every enabled edge.
  - Tc pulses on every 1->0 transition (up) or 0->1 transition (down).
- X/Z on Mode while En=1 and rst=0 is illegal. The bench flags it with an assertion.

Test Plan:
1. Reset: WIDTH=4, RST_VAL=4'hA, rst=1 for 2 edges with En=1, Mode=10 -> Q=4'hA, Qn=4'h5, Tc=0, Chg=0 after each edge.
2. Toggle:
   - rst=0, En=1, Mode=00, Q=0, T=4'b0101 for 2 edges -> Q=4'h5, then 4'h0, with Chg=1 both cycles.
   - T=0 -> Q holds 4'h0, Chg=0.
3. Load then hold: Mode=01, D=4'h9 -> Q=4'h9, Chg=1; then En=0 with D=4'h3 for 3 edges -> Q stays 4'h9, Chg=0, Tc=0.
4. Count-up wrap: load 4'hE, then Mode=10 for 3 edges -> Q=F, 0, 1; Tc=1 only in the cycle Q first reads 0; Chg=1 each cycle.
5. Count-down wrap, then reset mid-count: load 4'h1, Mode=11 -> Q=0, F (Tc=1 with Q=F, then 0); assert rst on the next edge -> Q=RST_VAL, Tc=0, Chg=0.
6. Width sweep: repeat scenarios 2 and 4 with WIDTH=1 and WIDTH=8 -> WIDTH=8 up-count from 8'hFE gives FF, 00 with Tc pulse; WIDTH=1 toggles each edge.

Source files
------------

// File: rtl/tff_array.sv
// Bank of WIDTH edge-triggered toggle flip-flops with toggle, parallel-load and up/down-count modes.
// One-cycle latency from sampled inputs to Q/Tc/Chg; there is no backpressure, En=0 simply freezes state.
module tff_array #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Tc,
  output logic             Chg
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  logic [WIDTH-1:0] tgl_up;
  logic [WIDTH-1:0] tgl_dn;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] q_next;
  logic             run_up;
  logic             run_dn;
  logic             tc_next;

  // T-chain: bit i toggles once every lower bit is all-ones (up) or all-zeros (down).
  // After the loop the running terms equal "Q is all ones" / "Q is all zeros", i.e. the wrap condition.
  always_comb begin
    run_up = 1'b1;
    run_dn = 1'b1;
    tgl_up = '0;
    tgl_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tgl_up[i] = run_up;
      tgl_dn[i] = run_dn;
      run_up    = run_up & Q[i];
      run_dn    = run_dn & ~Q[i];
    end
  end

  // Every mode is expressed as a toggle vector so Chg falls out as "any bit toggles".
  always_comb begin
    tgl     = '0;
    tc_next = 1'b0;
    case (Mode)
      MODE_TOGGLE: tgl = T;
      MODE_LOAD:   tgl = Q ^ D;
      MODE_UP: begin
        tgl     = tgl_up;
        tc_next = run_up;
      end
      MODE_DOWN: begin
        tgl     = tgl_dn;
        tc_next = run_dn;
      end
      default: tgl = '0;
    endcase
    q_next = Q ^ tgl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q   <= RST_VAL;
      Tc  <= 1'b0;
      Chg <= 1'b0;
    end else if (!En) begin
      Tc  <= 1'b0;
      Chg <= 1'b0;
    end else begin
      Q   <= q_next;
      Tc  <= tc_next;
      Chg <= |tgl;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_tff_array.sv
// Directed bench for tff_array at WIDTH 4 (RST_VAL=A), 8 and 1, with hand-computed expectations.
module tb_tff_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] t;
  logic [7:0] d;

  logic [3:0] q4, qn4;
  logic       tc4, chg4;
  logic [7:0] q8, qn8;
  logic       tc8, chg8;
  logic [0:0] q1, qn1;
  logic       tc1, chg1;

  int nchecks = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  tff_array #(.WIDTH(4), .RST_VAL(4'hA)) dut4 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .T(t[3:0]), .D(d[3:0]),
    .Q(q4), .Qn(qn4), .Tc(tc4), .Chg(chg4));

  tff_array #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .T(t), .D(d),
    .Q(q8), .Qn(qn8), .Tc(tc8), .Chg(chg8));

  tff_array #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .T(t[0:0]), .D(d[0:0]),
    .Q(q1), .Qn(qn1), .Tc(tc1), .Chg(chg1));

  // An undefined Mode is only illegal while it would actually be used.
  always @(posedge clk) begin
    if (rst === 1'b0 && en === 1'b1)
      assert (!$isunknown(mode)) else $error("illegal Mode value %b while enabled", mode);
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       chg;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] tv, input logic [7:0] dv);
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    t    = tv;
    d    = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] eq, input logic etc, input logic echg);
    check({name, "_q"},   {24'h0, q8},  {24'h0, eq});
    check({name, "_qn"},  {24'h0, qn8}, {24'h0, ~eq});
    check({name, "_tc"},  {31'h0, tc8}, {31'h0, etc});
    check({name, "_chg"}, {31'h0, chg8}, {31'h0, echg});
  endtask

  task automatic check1(input string name, input logic eq, input logic etc, input logic echg);
    check({name, "_q"},   {31'h0, q1},   {31'h0, eq});
    check({name, "_qn"},  {31'h0, qn1},  {31'h0, ~eq});
    check({name, "_tc"},  {31'h0, tc1},  {31'h0, etc});
    check({name, "_chg"}, {31'h0, chg1}, {31'h0, echg});
  endtask

  initial begin
    logic [3:0] nq;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'b10;
    t    = '0;
    d    = '0;

    //             rst   en    mode   t     d     q     tc    chg
    vecs[0]  = '{1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'hA, 1'b0, 1'b0};  // reset, count-up ignored
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'hA, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};  // clear via load
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 4'h5, 4'h0, 4'h5, 1'b0, 1'b1};  // toggle 0101
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};  // T=0 holds
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h9, 4'h9, 1'b0, 1'b1};  // load 9
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 4'h0, 4'h3, 4'h9, 1'b0, 1'b0};  // disabled x3
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 4'h0, 4'h3, 4'h9, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 4'h0, 4'h3, 4'h9, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 4'h0, 4'hE, 4'hE, 1'b0, 1'b1};  // load E
    vecs[11] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1};  // count up
    vecs[12] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};  // wrap
    vecs[13] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 2'b01, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0};  // load same value
    vecs[15] = '{1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};  // count down
    vecs[16] = '{1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1};  // wrap under
    vecs[17] = '{1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'hA, 1'b0, 1'b0};  // reset mid-count
    vecs[18] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'hB, 1'b0, 1'b1};  // resumes from RST_VAL
    vecs[19] = '{1'b0, 1'b0, 2'b10, 4'h0, 4'h0, 4'hB, 1'b0, 1'b0};  // En=0 beats Mode

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, {4'h0, vecs[i].t}, {4'h0, vecs[i].d});
      nq = ~vecs[i].q;
      check($sformatf("w4_v%0d_q", i),   {28'h0, q4},   {28'h0, vecs[i].q});
      check($sformatf("w4_v%0d_qn", i),  {28'h0, qn4},  {28'h0, nq});
      check($sformatf("w4_v%0d_tc", i),  {31'h0, tc4},  {31'h0, vecs[i].tc});
      check($sformatf("w4_v%0d_chg", i), {31'h0, chg4}, {31'h0, vecs[i].chg});
    end

    // WIDTH=8: toggle pattern, then up-count wrap from FE.
    step(1'b1, 1'b1, 2'b10, 8'h00, 8'h00);  check8("w8_rst", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00);  check8("w8_tg1", 8'h5A, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00);  check8("w8_tg2", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);  check8("w8_tg0", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b01, 8'h00, 8'hFE);  check8("w8_ld",  8'hFE, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);  check8("w8_up1", 8'hFF, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);  check8("w8_up2", 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);  check8("w8_up3", 8'h01, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b11, 8'h00, 8'h00);  check8("w8_dn1", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b11, 8'h00, 8'h00);  check8("w8_dn2", 8'hFF, 1'b1, 1'b1);

    // WIDTH=1: every enabled count edge toggles; Tc marks 1->0 (up) and 0->1 (down).
    step(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);  check1("w1_rst", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 8'h01, 8'h00);  check1("w1_tg1", 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 8'h01, 8'h00);  check1("w1_tg2", 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);  check1("w1_tg0", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);  check1("w1_up1", 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);  check1("w1_up2", 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b11, 8'h00, 8'h00);  check1("w1_dn1", 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b11, 8'h00, 8'h00);  check1("w1_dn2", 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b11, 8'h00, 8'h00);  check1("w1_hold", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
